// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width, buffer defaults and the TX handshake state encoding.
package uart_pkg;

    localparam int UART_DATA_W          = 8;
    localparam int DEFAULT_DEPTH        = 16;
    localparam int DEFAULT_BUSY_TIMEOUT = 15;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } tx_state_t;

    // Bits needed to hold 0..max_val; never less than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Circular byte store with wrapping pointers and a separately tracked occupancy count.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [UART_DATA_W-1:0] wr_data,
    input  logic                   pop,
    output logic [UART_DATA_W-1:0] rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [ADDR_W:0]        count
);

    localparam logic [ADDR_W-1:0] PTR_INC    = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_INC    = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    logic [UART_DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]      wr_ptr;
    logic [ADDR_W-1:0]      rd_ptr;
    logic [ADDR_W:0]        count_next;

    assign rd_data = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + CNT_INC;
        else if (pop && !push)
            count_next = count - CNT_INC;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wr_data;
    end

    // Flags are derived from the next count so they are registered alongside it.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_INC;
            if (pop)
                rd_ptr <= rd_ptr + PTR_INC;
            count <= count_next;
            full  <= (count_next == FULL_COUNT);
            empty <= (count_next == '0);
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte buffer ahead of the UART transmitter; drains one byte per Tx_WR/Tx_BUSY handshake.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH        = DEFAULT_DEPTH,
    parameter int ADDR_W       = $clog2(DEPTH),
    parameter int BUSY_TIMEOUT = DEFAULT_BUSY_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [UART_DATA_W-1:0] wr_data,
    input  logic                   wr_en,
    input  logic                   tx_en,
    output logic                   full,
    output logic                   empty,
    output logic [ADDR_W:0]        count,
    output logic                   overflow,
    output logic                   timeout_err,
    output logic [UART_DATA_W-1:0] Tx_DATA,
    output logic                   Tx_WR,
    input  logic                   Tx_BUSY
);

    localparam int              TMR_W   = cnt_width(BUSY_TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(BUSY_TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_INC = TMR_W'(1);

    tx_state_t              state;
    logic [TMR_W-1:0]       tmr;
    logic                   pop;
    logic                   push;
    logic [UART_DATA_W-1:0] head_data;

    // A pop frees a slot in the same cycle, so a full buffer can still take a byte then.
    assign pop  = (state == IDLE) && tx_en && !empty && !Tx_BUSY;
    assign push = wr_en && (!full || pop);

    uart_fifo_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (wr_data),
        .pop     (pop),
        .rd_data (head_data),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    always_ff @(posedge clk) begin
        if (rst)
            overflow <= 1'b0;
        else if (wr_en && !push)
            overflow <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            tmr         <= '0;
            timeout_err <= 1'b0;
            Tx_WR       <= 1'b0;
            Tx_DATA     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        Tx_DATA <= head_data;
                        Tx_WR   <= 1'b1;
                        state   <= WRITE;
                    end
                end
                WRITE: begin
                    Tx_WR <= 1'b0;
                    tmr   <= '0;
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (Tx_BUSY) begin
                        state <= WAIT_DONE;
                    end else if (tmr == TMR_MAX) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        tmr <= tmr + TMR_INC;
                    end
                end
                WAIT_DONE: begin
                    if (!Tx_BUSY)
                        state <= IDLE;
                end
                default: begin
                    Tx_WR <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a simple transmitter model driving Tx_BUSY.
module tb_uart_tx_fifo;

    logic       clk;
    logic       rst;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       tx_en;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;
    logic       timeout_err;
    logic [7:0] Tx_DATA;
    logic       Tx_WR;
    logic       Tx_BUSY;

    int         checks   = 0;
    int         failures = 0;
    logic       never_busy;
    int         busy_left;
    logic [7:0] sent[$];

    uart_tx_fifo #(
        .DEPTH        (16),
        .ADDR_W       (4),
        .BUSY_TIMEOUT (15)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_data     (wr_data),
        .wr_en       (wr_en),
        .tx_en       (tx_en),
        .full        (full),
        .empty       (empty),
        .count       (count),
        .overflow    (overflow),
        .timeout_err (timeout_err),
        .Tx_DATA     (Tx_DATA),
        .Tx_WR       (Tx_WR),
        .Tx_BUSY     (Tx_BUSY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transmitter model: busy for 10 cycles starting one cycle after Tx_WR.
    assign Tx_BUSY = (busy_left != 0);
    always @(posedge clk) begin
        if (rst)
            busy_left <= 0;
        else if (Tx_WR && !never_busy)
            busy_left <= 10;
        else if (busy_left != 0)
            busy_left <= busy_left - 1;
        if (Tx_WR)
            sent.push_back(Tx_DATA);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_wr(input string tag);
        for (int i = 0; i < 60; i++) begin
            if (Tx_WR === 1'b1) break;
            @(negedge clk);
        end
        check(tag, 32'(Tx_WR), 32'd1);
    endtask

    initial begin
        rst        = 1'b1;
        wr_en      = 1'b0;
        wr_data    = 8'h00;
        tx_en      = 1'b0;
        never_busy = 1'b0;
        busy_left  = 0;
        repeat (2) @(negedge clk);
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_timeout", 32'(timeout_err), 32'd0);
        check("rst_txwr", 32'(Tx_WR), 32'd0);
        check("rst_txdata", 32'(Tx_DATA), 32'h00);
        rst = 1'b0;
        @(negedge clk);

        // Single byte: Tx_WR two cycles after the push.
        sent.delete();
        tx_en = 1'b1; wr_en = 1'b1; wr_data = 8'hA5;
        @(negedge clk);
        wr_en = 1'b0;
        check("t1_count_n1", 32'(count), 32'd1);
        check("t1_empty_n1", 32'(empty), 32'd0);
        check("t1_txwr_n1", 32'(Tx_WR), 32'd0);
        @(negedge clk);
        check("t1_txwr_n2", 32'(Tx_WR), 32'd1);
        check("t1_txdata_n2", 32'(Tx_DATA), 32'hA5);
        check("t1_empty_n2", 32'(empty), 32'd1);
        @(negedge clk);
        check("t1_txwr_n3", 32'(Tx_WR), 32'd0);
        repeat (25) @(negedge clk);
        check("t1_sent_n", 32'(sent.size()), 32'd1);
        check("t1_txdata_hold", 32'(Tx_DATA), 32'hA5);

        // Fill with tx_en low, push during the pop cycle, then overflow.
        sent.delete();
        tx_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            @(negedge clk);
        end
        check("t2_full", 32'(full), 32'd1);
        check("t2_count", 32'(count), 32'd16);
        check("t2_overflow0", 32'(overflow), 32'd0);
        check("t2_nosend", 32'(sent.size()), 32'd0);
        tx_en = 1'b1; wr_data = 8'hEE;
        @(negedge clk);
        check("t3_count", 32'(count), 32'd16);
        check("t3_overflow", 32'(overflow), 32'd0);
        check("t3_txwr", 32'(Tx_WR), 32'd1);
        check("t3_txdata", 32'(Tx_DATA), 32'h00);
        tx_en = 1'b0; wr_data = 8'hFF;
        @(negedge clk);
        wr_en = 1'b0;
        check("t2_overflow1", 32'(overflow), 32'd1);
        check("t2_count_ovf", 32'(count), 32'd16);
        repeat (30) @(negedge clk);
        check("t2_paused", 32'(sent.size()), 32'd1);
        tx_en = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (sent.size() >= 17) break;
            @(negedge clk);
        end
        repeat (30) @(negedge clk);
        check("t2_sent_n", 32'(sent.size()), 32'd17);
        for (int i = 0; i < 17 && i < sent.size(); i++)
            check($sformatf("t2_byte%0d", i), 32'(sent[i]), (i < 16) ? 32'(i) : 32'hEE);
        check("t2_empty", 32'(empty), 32'd1);
        check("t2_count0", 32'(count), 32'd0);

        // tx_en dropped during WAIT_BUSY: current byte completes, no new pop.
        sent.delete();
        wr_en = 1'b1; wr_data = 8'h11;
        @(negedge clk);
        wr_data = 8'h22;
        @(negedge clk);
        wr_en = 1'b0;
        wait_wr("t6_wr1");
        check("t6_data1", 32'(Tx_DATA), 32'h11);
        @(negedge clk);
        tx_en = 1'b0;
        repeat (30) @(negedge clk);
        check("t6_sent_paused", 32'(sent.size()), 32'd1);
        check("t6_count_paused", 32'(count), 32'd1);
        check("t6_hold", 32'(Tx_DATA), 32'h11);
        tx_en = 1'b1;
        wait_wr("t6_wr2");
        check("t6_data2", 32'(Tx_DATA), 32'h22);
        repeat (20) @(negedge clk);
        check("t6_sent_n", 32'(sent.size()), 32'd2);
        check("t6_empty", 32'(empty), 32'd1);

        // Timeout: Tx_BUSY never rises.
        sent.delete();
        never_busy = 1'b1;
        check("t4_timeout0", 32'(timeout_err), 32'd0);
        wr_en = 1'b1; wr_data = 8'h33;
        @(negedge clk);
        wr_data = 8'h44;
        @(negedge clk);
        wr_en = 1'b0;
        wait_wr("t4_wr1");
        check("t4_data1", 32'(Tx_DATA), 32'h33);
        repeat (16) @(negedge clk);
        check("t4_timeout_early", 32'(timeout_err), 32'd0);
        @(negedge clk);
        check("t4_timeout_set", 32'(timeout_err), 32'd1);
        check("t4_txwr_idle", 32'(Tx_WR), 32'd0);
        @(negedge clk);
        check("t4_txwr2", 32'(Tx_WR), 32'd1);
        check("t4_data2", 32'(Tx_DATA), 32'h44);
        repeat (25) @(negedge clk);
        never_busy = 1'b0;
        check("t4_sent_n", 32'(sent.size()), 32'd2);
        check("t4_timeout_sticky", 32'(timeout_err), 32'd1);

        // Reset during WAIT_DONE of the first of three bytes.
        sent.delete();
        wr_en = 1'b1; wr_data = 8'h55;
        @(negedge clk);
        wr_data = 8'h66;
        @(negedge clk);
        wr_data = 8'h77;
        check("t5_txwr", 32'(Tx_WR), 32'd1);
        @(negedge clk);
        wr_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_count", 32'(count), 32'd0);
        check("t5_empty", 32'(empty), 32'd1);
        check("t5_full", 32'(full), 32'd0);
        check("t5_txwr0", 32'(Tx_WR), 32'd0);
        check("t5_txdata", 32'(Tx_DATA), 32'h00);
        check("t5_overflow", 32'(overflow), 32'd0);
        check("t5_timeout", 32'(timeout_err), 32'd0);
        repeat (40) @(negedge clk);
        check("t5_sent_n", 32'(sent.size()), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
